// File: rtl/cook_timer_if.sv
// cook_timer_if: keypad, magnetron and display signals of the cook timer
//   master drives clear/digit_valid/digit/mag_on and observes the outputs;
//   slave (the timer) is the reverse.
interface cook_timer_if;
  logic       clear;
  logic       digit_valid;
  logic [3:0] digit;
  logic       mag_on;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       tick;
  logic       timer_done;
  modport master (
    output clear, digit_valid, digit, mag_on,
    input  min_tens, min_ones, sec_tens, sec_ones, tick, timer_done
  );
  modport slave (
    input  clear, digit_valid, digit, mag_on,
    output min_tens, min_ones, sec_tens, sec_ones, tick, timer_done
  );
endinterface

// File: rtl/cook_timer.sv
// cook_timer: MM:SS BCD countdown timer with keypad digit entry
//   clk, rst (async, active high)
//   bus.slave: clear, digit_valid, digit, mag_on in;
//              min_tens, min_ones, sec_tens, sec_ones, tick, timer_done out
module cook_timer #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input logic         clk,
  input logic         rst,
  cook_timer_if.slave bus
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  logic [PW-1:0] pre;
  logic [3:0] mt, mo, st, so, mt_n, mo_n, st_n, so_n;
  logic done, run, step, entry, tick;
  assign done  = ~|{mt, mo, st, so};
  assign run   = bus.mag_on & ~done;
  assign step  = run & (pre == PW'(TICKS_PER_SEC - 1));
  assign entry = bus.digit_valid & ~bus.mag_on & (bus.digit <= 4'd9);
  // Borrow chain; min_tens never underflows because step requires ~done.
  always_comb begin
    so_n = (so != 4'd0) ? so - 4'd1 : 4'd9;
    st_n = (so != 4'd0) ? st : (st != 4'd0) ? st - 4'd1 : 4'd5;
    mo_n = ((so | st) != 4'd0) ? mo : (mo != 4'd0) ? mo - 4'd1 : 4'd9;
    mt_n = ((so | st | mo) != 4'd0) ? mt : mt - 4'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {mt, mo, st, so} <= '0;
      pre              <= '0;
      tick             <= 1'b0;
    end else if (bus.clear) begin
      {mt, mo, st, so} <= '0;
      pre              <= '0;
      tick             <= 1'b0;
    end else begin
      // Prescaler is held at 0 whenever not running, so pauses drop partial seconds.
      pre  <= (step || !run) ? '0 : pre + 1'b1;
      tick <= step;
      if (step)
        {mt, mo, st, so} <= {mt_n, mo_n, st_n, so_n};
      else if (entry)
        {mt, mo, st, so} <= {mo, st, so, bus.digit};
    end
  end
  assign bus.min_tens   = mt;
  assign bus.min_ones   = mo;
  assign bus.sec_tens   = st;
  assign bus.sec_ones   = so;
  assign bus.tick       = tick;
  assign bus.timer_done = done;
endmodule

// File: tb/tb_cook_timer.sv
// tb_cook_timer: scoreboard bench for cook_timer with TICKS_PER_SEC = 4
module tb_cook_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cook_timer_if bus();
  cook_timer #(.TICKS_PER_SEC(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    string       tag;
    logic [17:0] v;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got digits=%h done=%b tick=%b, want digits=%h done=%b tick=%b",
               tag, obs[17:2], obs[1], obs[0], exp[17:2], exp[1], exp[0]);
    end
  endtask
  task automatic push(input string tag, input logic [15:0] d, input logic done, input logic tk);
    exp_t e;
    e.tag = tag;
    e.v   = {d, done, tk};
    q.push_back(e);
  endtask
  task automatic pop_cmp();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
                    bus.timer_done, bus.tick}, e.v);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic enter(input logic [3:0] d);
    bus.digit       = d;
    bus.digit_valid = 1'b1;
    cyc(1);
    bus.digit_valid = 1'b0;
  endtask
  task automatic do_clear();
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
  endtask
  function automatic logic [15:0] bcd(input int s);
    logic [3:0] t, o;
    t = 4'(s / 10);
    o = 4'(s % 10);
    return {8'h00, t, o};
  endfunction
  initial begin
    bus.clear = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit = 4'd0;
    bus.mag_on = 1'b0;
    #2;
    push("reset", 16'h0000, 1'b1, 1'b0);
    pop_cmp();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.mag_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      push("zero_run", 16'h0000, 1'b1, 1'b0);
      pop_cmp();
    end
    bus.mag_on = 1'b0;
    enter(4'd1); enter(4'd3); enter(4'd0);
    push("entry_0130", 16'h0130, 1'b0, 1'b0);
    pop_cmp();
    bus.mag_on = 1'b1;
    cyc(3);
    push("pre_tick", 16'h0130, 1'b0, 1'b0);
    pop_cmp();
    cyc(1);
    push("tick_0129", 16'h0129, 1'b0, 1'b1);
    pop_cmp();
    cyc(1);
    push("tick_pulse", 16'h0129, 1'b0, 1'b0);
    pop_cmp();
    cyc(3);
    push("tick_0128", 16'h0128, 1'b0, 1'b1);
    pop_cmp();
    bus.mag_on = 1'b0;
    do_clear();
    push("clear_idle", 16'h0000, 1'b1, 1'b0);
    pop_cmp();
    enter(4'd1); enter(4'd0); enter(4'd0);
    push("entry_0100", 16'h0100, 1'b0, 1'b0);
    pop_cmp();
    bus.mag_on = 1'b1;
    for (int s = 59; s >= 0; s--) begin
      cyc(4);
      push("borrow_run", bcd(s), s == 0, 1'b1);
      pop_cmp();
    end
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      push("saturate", 16'h0000, 1'b1, 1'b0);
      pop_cmp();
    end
    bus.mag_on = 1'b0;
    enter(4'd9); enter(4'd9);
    enter(4'hA);
    push("ignore_A", 16'h0099, 1'b0, 1'b0);
    pop_cmp();
    bus.mag_on = 1'b1;
    enter(4'd7);
    push("ignore_run_digit", 16'h0099, 1'b0, 1'b0);
    pop_cmp();
    cyc(3);
    push("tick_0098", 16'h0098, 1'b0, 1'b1);
    pop_cmp();
    for (int s = 97; s >= 0; s--) begin
      cyc(4);
      push("count_99", bcd(s), s == 0, 1'b1);
      pop_cmp();
    end
    cyc(8);
    push("no_wrap", 16'h0000, 1'b1, 1'b0);
    pop_cmp();
    bus.mag_on = 1'b0;
    enter(4'd5);
    push("entry_5", 16'h0005, 1'b0, 1'b0);
    pop_cmp();
    bus.mag_on = 1'b1;
    cyc(2);
    bus.mag_on = 1'b0;
    cyc(3);
    push("pause_hold", 16'h0005, 1'b0, 1'b0);
    pop_cmp();
    bus.mag_on = 1'b1;
    cyc(3);
    push("resume_early", 16'h0005, 1'b0, 1'b0);
    pop_cmp();
    cyc(1);
    push("resume_tick", 16'h0004, 1'b0, 1'b1);
    pop_cmp();
    bus.mag_on = 1'b0;
    do_clear();
    enter(4'd4); enter(4'd5);
    push("entry_0045", 16'h0045, 1'b0, 1'b0);
    pop_cmp();
    bus.mag_on = 1'b1;
    cyc(3);
    do_clear();
    push("clear_running", 16'h0000, 1'b1, 1'b0);
    pop_cmp();
    bus.mag_on = 1'b0;
    enter(4'd2); enter(4'd1); enter(4'd0);
    bus.mag_on = 1'b1;
    cyc(2);
    push("pre_rst_0210", 16'h0210, 1'b0, 1'b0);
    pop_cmp();
    #2 rst = 1'b1;
    #1;
    push("async_rst", 16'h0000, 1'b1, 1'b0);
    pop_cmp();
    #1 rst = 1'b0;
    cyc(4);
    push("post_rst", 16'h0000, 1'b1, 1'b0);
    pop_cmp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
